// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg: shared types and defaults for the CSR port arbiter.
// Requester IDs double as the 1-bit entries of the response-owner FIFO.
package csr_arb_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } csr_req_id_e;

    localparam int unsigned MaxOutstandingDef = 4;

endpackage

// File: rtl/csr_arb_id_fifo.sv
// csr_arb_id_fifo: in-order FIFO of requester IDs for outstanding reads.
// Depth must be a power of two so the pointers wrap for free.
module csr_arb_id_fifo
    import csr_arb_pkg::*;
#(
    parameter int unsigned Depth    = MaxOutstandingDef,
    parameter int unsigned CntWidth = $clog2(Depth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  csr_req_id_e         id_i,
    input  logic                pop_i,
    output csr_req_id_e         head_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [Depth-1:0]    mem_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic [CntWidth-1:0] count_d;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = csr_req_id_e'(mem_q[rd_ptr_q]);

    // Qualify push/pop; a pop frees room for a push when full.
    always_comb begin
        do_push = push_i & (~full_o | pop_i);
        do_pop  = pop_i & ~empty_o;
        count_d = count_q;
        if (do_push & ~do_pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (do_pop & ~do_push) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// csr_arbiter: round-robin share of one CSR port between host (A) and
// loader (B); read responses routed back in order via an ID FIFO.
module csr_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned  CsrDataWidth   = 32,
    parameter int unsigned  CsrAddrWidth   = 32,
    parameter int unsigned  MaxOutstanding = MaxOutstandingDef,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [CsrDataWidth-1:0] a_req_data_i,
    input  logic [CsrAddrWidth-1:0] a_req_addr_i,
    input  logic                    a_req_write_i,
    input  logic                    a_req_valid_i,
    output logic                    a_req_ready_o,
    output logic [CsrDataWidth-1:0] a_rsp_data_o,
    output logic                    a_rsp_valid_o,
    input  logic                    a_rsp_ready_i,
    input  logic [CsrDataWidth-1:0] b_req_data_i,
    input  logic [CsrAddrWidth-1:0] b_req_addr_i,
    input  logic                    b_req_write_i,
    input  logic                    b_req_valid_i,
    output logic                    b_req_ready_o,
    output logic [CsrDataWidth-1:0] b_rsp_data_o,
    output logic                    b_rsp_valid_o,
    input  logic                    b_rsp_ready_i,
    output logic [CsrDataWidth-1:0] csr_req_data_o,
    output logic [CsrAddrWidth-1:0] csr_req_addr_o,
    output logic                    csr_req_write_o,
    output logic                    csr_req_valid_o,
    input  logic                    csr_req_ready_i,
    input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
    input  logic                    csr_rsp_valid_i,
    output logic                    csr_rsp_ready_o,
    output logic                    arb_full_o
);

    csr_req_id_e         ptr_q;
    csr_req_id_e         ptr_d;
    csr_req_id_e         sel_id;
    csr_req_id_e         own_id;
    csr_req_id_e         fifo_head;
    logic                a_elig;
    logic                b_elig;
    logic                sel_vld;
    logic                accept;
    logic                acc_read;
    logic                own_vld;
    logic                rsp_hs;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CntWidth-1:0] fifo_cnt;

    assign arb_full_o = (fifo_cnt == CntWidth'(MaxOutstanding));

    // Eligibility, grant and downstream request mux; reset forces all idle.
    always_comb begin
        a_elig = rst_ni & a_req_valid_i & (a_req_write_i | ~fifo_full);
        b_elig = rst_ni & b_req_valid_i & (b_req_write_i | ~fifo_full);
        sel_vld = a_elig | b_elig;
        sel_id  = REQ_A;
        if (a_elig & b_elig) begin
            sel_id = ptr_q;
        end else if (b_elig) begin
            sel_id = REQ_B;
        end
        csr_req_valid_o = sel_vld;
        csr_req_data_o  = '0;
        csr_req_addr_o  = '0;
        csr_req_write_o = 1'b0;
        a_req_ready_o   = 1'b0;
        b_req_ready_o   = 1'b0;
        if (sel_vld) begin
            unique case (sel_id)
                REQ_A: begin
                    csr_req_data_o  = a_req_data_i;
                    csr_req_addr_o  = a_req_addr_i;
                    csr_req_write_o = a_req_write_i;
                    a_req_ready_o   = csr_req_ready_i;
                end
                REQ_B: begin
                    csr_req_data_o  = b_req_data_i;
                    csr_req_addr_o  = b_req_addr_i;
                    csr_req_write_o = b_req_write_i;
                    b_req_ready_o   = csr_req_ready_i;
                end
            endcase
        end
        accept   = sel_vld & csr_req_ready_i;
        acc_read = accept & ~csr_req_write_o;
        ptr_d    = ptr_q;
        if (accept) begin
            ptr_d = (sel_id == REQ_A) ? REQ_B : REQ_A;
        end
    end

    // Response owner: FIFO head, else a read accepted this very cycle.
    always_comb begin
        own_vld         = ~fifo_empty | acc_read;
        own_id          = fifo_empty ? sel_id : fifo_head;
        a_rsp_valid_o   = 1'b0;
        a_rsp_data_o    = '0;
        b_rsp_valid_o   = 1'b0;
        b_rsp_data_o    = '0;
        csr_rsp_ready_o = 1'b0;
        if (own_vld) begin
            unique case (own_id)
                REQ_A: begin
                    a_rsp_valid_o   = csr_rsp_valid_i;
                    a_rsp_data_o    = csr_rsp_data_i;
                    csr_rsp_ready_o = a_rsp_ready_i;
                end
                REQ_B: begin
                    b_rsp_valid_o   = csr_rsp_valid_i;
                    b_rsp_data_o    = csr_rsp_data_i;
                    csr_rsp_ready_o = b_rsp_ready_i;
                end
            endcase
        end
        rsp_hs = csr_rsp_valid_i & csr_rsp_ready_o;
        push   = acc_read & ~(fifo_empty & rsp_hs);
        pop    = rsp_hs & ~fifo_empty;
    end

    // Round-robin priority pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    csr_arb_id_fifo #(
        .Depth(MaxOutstanding)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .id_i   (sel_id),
        .pop_i  (pop),
        .head_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    // A downstream response with nobody waiting for it is a protocol error.
    a_rsp_has_owner : assert property (
        @(posedge clk_i) disable iff (!rst_ni) csr_rsp_valid_i |-> own_vld
    );

endmodule

// File: doc/csr_arbiter.md
Name: csr_arbiter

Overview:
- Two-requester arbiter that shares the single CSR request/response port of the accelerator control block.
- Port A is the host; port B is the instruction/config loader.
- Grants requests round-robin, forwards one request per cycle downstream, and routes in-order read responses back to the issuing requester.
- Sits between the system interconnect/loader and the CSR block; fully transparent when only one requester is active.

Parameters:
- CsrDataWidth, 32, CSR data width.
- CsrAddrWidth, 32, CSR address width.
- MaxOutstanding, 4, max reads issued but not yet responded; power of two, >=2.
- CntWidth, $clog2(MaxOutstanding)+1, outstanding counter width (derived; don't override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset (see Behaviour).
- a_req_data_i / b_req_data_i  in  CsrDataWidth  write data.
- a_req_addr_i / b_req_addr_i  in  CsrAddrWidth  register address.
- a_req_write_i / b_req_write_i  in  1  1=write, 0=read.
- a_req_valid_i / b_req_valid_i  in  1  request valid.
- a_req_ready_o / b_req_ready_o  out  1  request accepted.
- a_rsp_data_o / b_rsp_data_o  out  CsrDataWidth  read data.
- a_rsp_valid_o / b_rsp_valid_o  out  1  response valid.
- a_rsp_ready_i / b_rsp_ready_i  in  1  response accepted.
- csr_req_data_o, csr_req_addr_o, csr_req_write_o, csr_req_valid_o  out  CsrDataWidth/CsrAddrWidth/1/1  downstream request.
- csr_req_ready_i  in  1  downstream ready.
- csr_rsp_data_i  in  CsrDataWidth  downstream read data.
- csr_rsp_valid_i  in  1  downstream response valid.
- csr_rsp_ready_o  out  1  downstream response ready.
- arb_full_o  out  1  outstanding-read tracker full.

Behaviour:
- Reset and clocking: one clock `clk_i`; reset `rst_ni` is asynchronous, active-low.
- Reset state: priority pointer = A, ID FIFO empty, count = 0.
- Reset outputs: all outputs are 0 with all valids low; arb_full_o = 0.
- Eligibility: a requester is eligible if valid and (write, or count < MaxOutstanding). Reads are blocked while full; a same-cycle pop does not free a slot for the same cycle.
- Arbitration (combinational):
  - Only one eligible: select it.
  - Both eligible: select the priority-pointer side.
  - Selected request drives csr_req_* with csr_req_valid_o = 1.
  - Selected requester's ready = csr_req_ready_i; the other ready = 0.
- Priority pointer: on each accepted request (selected valid & csr_req_ready_i), the pointer moves to the side not granted. It is unchanged when nothing is accepted.
- Response owner:
  - FIFO non-empty: owner = FIFO head ID.
  - FIFO empty: owner = the requester whose read is accepted this cycle. This is the zero-latency pass-through case, where the CSR answers in the same cycle.
  - No owner: csr_rsp_ready_o = 0 and both rsp_valid = 0.
- Response routing: owner's rsp_valid = csr_rsp_valid_i, owner's rsp_data = csr_rsp_data_i; non-owner gets valid 0, data 0. csr_rsp_ready_o = owner's rsp_ready.
- Push: accepted read, except when FIFO is empty and the response handshake completes in the same cycle (pass-through, nothing stored).
- Pop: response handshake while FIFO non-empty.
- Push and pop in the same cycle: count unchanged, head advances.
- Accepted writes never push; downstream produces no response for writes.
- Ordering: responses are assumed in order. A csr_rsp_valid_i with no owner is ignored (not consumed) and flagged by an assertion.
- Latency: request is zero-cycle combinational path to downstream; response is zero-cycle routing. There are no registers in the data path.
- arb_full_o = (count == MaxOutstanding), registered-state derived.
- Reset mid-operation: FIFO and count are cleared and in-flight responses are lost. Requesters must re-issue.

Decomposition:
- Package csr_arb_pkg:
  - typedef enum logic {REQ_A=0, REQ_B=1} csr_req_id_e.
  - Parameter default MaxOutstanding.
- Sub-module csr_arb_id_fifo:
  - Depth MaxOutstanding, 1-bit entries, push/pop/full/empty/count.
  - Simultaneous push+pop allowed when full or empty-with-push.

Test Plan:
- Only A issues read addr 0x1 with CSR zero-latency response 0xAB: a_rsp_valid_o same cycle with data 0xAB; FIFO stays empty; b_rsp_valid_o = 0.
- A and B both valid (writes) for 4 cycles, ready = 1: grants A,B,A,B. The pointer then points to A. Downstream sees the alternating addresses/data.
- Downstream rsp_ready-stalled model (responds 2 cycles late), B issues 4 reads: arb_full_o = 1 after the 4th. A 5th B read is held (b_req_ready_o = 0) while a B write passes. Four responses route to B in order.
- Interleaved A read, B read, A read with delayed responses 0x11, 0x22, 0x33: A gets 0x11 and 0x33, B gets 0x22, in order.
- Owner backpressure: a_rsp_ready_i = 0 for 3 cycles → csr_rsp_ready_o = 0 and no pop. Release → pop, count decremented.
- Assert rst_ni with 2 reads outstanding: arb_full_o = 0, count = 0, all outputs 0 immediately (asynchronously). After release, priority = A.
